// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: opcodes,
// datapath select codes, FSM state type and the decoded control vector.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR, ST_EXEC,
    ST_ALUWB, ST_BEQ, ST_BNE, ST_IMMEX, ST_IMMWB, ST_JUMP, ST_TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle: opcode and memory handshake in, control strobes out.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       immzext;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, mem_ready,
    output mem_req, memwrite, irwrite, pcwrite, branch, branch_ne, iord,
           alusrca, alusrcb, immzext, aluop, pcsrc, regdst, memtoreg,
           regwrite, instr_done, illegal
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, memwrite, irwrite, pcwrite, branch, branch_ne, iord,
           alusrca, alusrcb, immzext, aluop, pcsrc, regdst, memtoreg,
           regwrite, instr_done, illegal
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Pure state -> control-vector decoder for the multicycle controller.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   imm_ori,
  output ctrl_t  cv
);

  always_comb begin
    cv = '0;
    case (state)
      ST_FETCH: begin
        cv.mem_req = 1'b1;
        cv.irwrite = 1'b1;
        cv.pcwrite = 1'b1;
        cv.alusrcb = SRCB_FOUR;
        cv.aluop   = ALUOP_ADD;
        cv.pcsrc   = PCSRC_ALU;
      end
      ST_DECODE: begin
        cv.alusrcb = SRCB_IMMSH;
        cv.aluop   = ALUOP_ADD;
      end
      ST_MEMADR, ST_IMMEX: begin
        cv.alusrca = 1'b1;
        cv.alusrcb = SRCB_IMM;
        // ORI is the only immediate op that zero-extends and ORs
        if (state == ST_IMMEX && imm_ori) begin
          cv.aluop   = ALUOP_OR;
          cv.immzext = 1'b1;
        end
      end
      ST_MEMRD: begin
        cv.mem_req = 1'b1;
        cv.iord    = 1'b1;
      end
      ST_MEMWB: begin
        cv.regwrite   = 1'b1;
        cv.memtoreg   = 1'b1;
        cv.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        cv.mem_req    = 1'b1;
        cv.memwrite   = 1'b1;
        cv.iord       = 1'b1;
        cv.instr_done = 1'b1;
      end
      ST_EXEC: begin
        cv.alusrca = 1'b1;
        cv.alusrcb = SRCB_B;
        cv.aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        cv.regwrite   = 1'b1;
        cv.regdst     = 1'b1;
        cv.instr_done = 1'b1;
      end
      ST_BEQ, ST_BNE: begin
        cv.alusrca    = 1'b1;
        cv.aluop      = ALUOP_SUB;
        cv.pcsrc      = PCSRC_ALUOUT;
        cv.branch     = (state == ST_BEQ);
        cv.branch_ne  = (state == ST_BNE);
        cv.instr_done = 1'b1;
      end
      ST_IMMWB: begin
        cv.regwrite   = 1'b1;
        cv.instr_done = 1'b1;
      end
      ST_JUMP: begin
        cv.pcsrc      = PCSRC_JUMP;
        cv.pcwrite    = 1'b1;
        cv.instr_done = 1'b1;
      end
      ST_TRAP: cv.illegal = 1'b1;
      default: cv = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: state register, next-state logic and
// memory-handshake gating around the state decoder.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit EXT_EN      = 1'b1,
  parameter bit TRAP_HALT   = 1'b0
) (
  input logic                   clk,
  input logic                   reset_n,
  mips_multicycle_ctrl_if.master bus
);

  state_t state, state_nxt;
  logic   imm_ori;
  logic   rdy;
  ctrl_t  cv;

  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // op is only valid in DECODE, so the ADDI/ORI choice is captured there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_FETCH;
      imm_ori <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) imm_ori <= EXT_EN && (bus.op == OP_ORI);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (rdy) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = ST_MEMADR;
          OP_RTYPE:     state_nxt = ST_EXEC;
          OP_BEQ:       state_nxt = ST_BEQ;
          OP_BNE:       state_nxt = EXT_EN ? ST_BNE : ST_TRAP;
          OP_ADDI:      state_nxt = ST_IMMEX;
          OP_ORI:       state_nxt = EXT_EN ? ST_IMMEX : ST_TRAP;
          OP_J:         state_nxt = ST_JUMP;
          default:      state_nxt = ST_TRAP;
        endcase
      end
      ST_MEMADR: state_nxt = (bus.op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (rdy) state_nxt = ST_MEMWB;
      ST_MEMWR:  if (rdy) state_nxt = ST_FETCH;
      ST_EXEC:   state_nxt = ST_ALUWB;
      ST_IMMEX:  state_nxt = ST_IMMWB;
      ST_TRAP:   state_nxt = TRAP_HALT ? ST_TRAP : ST_FETCH;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state   (state),
    .imm_ori (imm_ori),
    .cv      (cv)
  );

  // Fetch strobes and the store's completion wait on the memory handshake;
  // the decoder's JUMP pcwrite stays unconditional.
  assign bus.irwrite    = cv.irwrite & rdy;
  assign bus.pcwrite    = cv.pcwrite & ((state != ST_FETCH) | rdy);
  assign bus.instr_done = cv.instr_done & ((state != ST_MEMWR) | rdy);
  assign bus.mem_req    = cv.mem_req;
  assign bus.memwrite   = cv.memwrite;
  assign bus.branch     = cv.branch;
  assign bus.branch_ne  = cv.branch_ne;
  assign bus.iord       = cv.iord;
  assign bus.alusrca    = cv.alusrca;
  assign bus.alusrcb    = cv.alusrcb;
  assign bus.immzext    = cv.immzext;
  assign bus.aluop      = cv.aluop;
  assign bus.pcsrc      = cv.pcsrc;
  assign bus.regdst     = cv.regdst;
  assign bus.memtoreg   = cv.memtoreg;
  assign bus.regwrite   = cv.regwrite;
  assign bus.illegal    = cv.illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: per-cycle expected control vectors from an instruction-level model.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       immzext;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       instr_done;
    logic       illegal;
  } cv_t;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cv_t   q0[$];
  cv_t   q1[$];
  string n0[$];
  string n1[$];
  cv_t   a0, a1;

  mips_multicycle_ctrl_if if0();
  mips_multicycle_ctrl_if if1();

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1), .EXT_EN(1'b1), .TRAP_HALT(1'b0)) u0 (
    .clk(clk), .reset_n(rst0), .bus(if0)
  );
  mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b0), .EXT_EN(1'b0), .TRAP_HALT(1'b1)) u1 (
    .clk(clk), .reset_n(rst1), .bus(if1)
  );

  always #5 clk = ~clk;

  assign a0 = {if0.mem_req, if0.memwrite, if0.irwrite, if0.pcwrite, if0.branch,
               if0.branch_ne, if0.iord, if0.alusrca, if0.alusrcb, if0.immzext,
               if0.aluop, if0.pcsrc, if0.regdst, if0.memtoreg, if0.regwrite,
               if0.instr_done, if0.illegal};
  assign a1 = {if1.mem_req, if1.memwrite, if1.irwrite, if1.pcwrite, if1.branch,
               if1.branch_ne, if1.iord, if1.alusrca, if1.alusrcb, if1.immzext,
               if1.aluop, if1.pcsrc, if1.regdst, if1.memtoreg, if1.regwrite,
               if1.instr_done, if1.illegal};

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected control vector for one cycle of an instruction phase, straight
  // from the phase table of the control unit.
  function automatic cv_t exp_cv(input string nm, input bit rdy);
    cv_t c;
    c = '0;
    case (nm)
      "fetch":  begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pcwrite = rdy; end
      "decode": c.alusrcb = 2'b11;
      "addr":   begin c.alusrca = 1; c.alusrcb = 2'b10; end
      "rd":     begin c.mem_req = 1; c.iord = 1; end
      "rdwb":   begin c.regwrite = 1; c.memtoreg = 1; c.instr_done = 1; end
      "wr":     begin c.mem_req = 1; c.memwrite = 1; c.iord = 1; c.instr_done = rdy; end
      "exec":   begin c.alusrca = 1; c.aluop = 2'b10; end
      "aluwb":  begin c.regwrite = 1; c.regdst = 1; c.instr_done = 1; end
      "beq":    begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1; c.instr_done = 1; end
      "bne":    begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch_ne = 1; c.instr_done = 1; end
      "addi":   begin c.alusrca = 1; c.alusrcb = 2'b10; end
      "ori":    begin c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = 2'b11; c.immzext = 1; end
      "immwb":  begin c.regwrite = 1; c.instr_done = 1; end
      "jump":   begin c.pcsrc = 2'b10; c.pcwrite = 1; c.instr_done = 1; end
      "trap":   c.illegal = 1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // u1 ignores mem_ready, so it is always driven low there and the model
  // expects the "ready" variant of every phase.
  task automatic one_cycle(input int d, input string nm, input bit rdy, input logic [5:0] opv);
    @(posedge clk);
    #1;
    if (d == 0) begin
      if0.mem_ready = rdy;
      if0.op = opv;
      q0.push_back(exp_cv(nm, rdy));
      n0.push_back(nm);
    end else begin
      if1.mem_ready = 1'b0;
      if1.op = opv;
      q1.push_back(exp_cv(nm, 1'b1));
      n1.push_back(nm);
    end
  endtask

  task automatic run_instr(input int d, input logic [5:0] opv, input int wf, input int wm,
                           input bit skipf);
    bit ext;
    ext = (d == 0);
    if (!skipf) begin
      repeat (wf) one_cycle(d, "fetch", 1'b0, rop());
      one_cycle(d, "fetch", 1'b1, rop());
    end
    one_cycle(d, "decode", rb(), opv);
    case (opv)
      6'b100011: begin
        one_cycle(d, "addr", rb(), opv);
        repeat (wm) one_cycle(d, "rd", 1'b0, rop());
        one_cycle(d, "rd", 1'b1, rop());
        one_cycle(d, "rdwb", rb(), rop());
      end
      6'b101011: begin
        one_cycle(d, "addr", rb(), opv);
        repeat (wm) one_cycle(d, "wr", 1'b0, rop());
        one_cycle(d, "wr", 1'b1, rop());
      end
      6'b000000: begin
        one_cycle(d, "exec", rb(), rop());
        one_cycle(d, "aluwb", rb(), rop());
      end
      6'b000100: one_cycle(d, "beq", rb(), rop());
      6'b000101: one_cycle(d, ext ? "bne" : "trap", rb(), rop());
      6'b001000: begin
        one_cycle(d, "addi", rb(), rop());
        one_cycle(d, "immwb", rb(), rop());
      end
      6'b001101: begin
        if (ext) begin
          one_cycle(d, "ori", rb(), rop());
          one_cycle(d, "immwb", rb(), rop());
        end else begin
          one_cycle(d, "trap", rb(), rop());
        end
      end
      6'b000010: one_cycle(d, "jump", rb(), rop());
      default:   one_cycle(d, "trap", rb(), rop());
    endcase
  endtask

  // Reset pulse on u1 (which leaves FETCH immediately once released).
  task automatic u1_reset_pulse();
    one_cycle(1, "fetch", 1'b0, rop());
    rst1 = 1'b0;
    one_cycle(1, "fetch", 1'b0, rop());
    rst1 = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0) check({"u0 ", n0.pop_front()}, a0, q0.pop_front());
    if (q1.size() != 0) check({"u1 ", n1.pop_front()}, a1, q1.pop_front());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] oplist[9];

  initial begin
    if0.op = '0; if0.mem_ready = 1'b0;
    if1.op = '0; if1.mem_ready = 1'b0;
    oplist = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
               6'b001000, 6'b001101, 6'b000010, 6'b111111};

    // u0 reset: FETCH values with irwrite/pcwrite following mem_ready
    one_cycle(0, "fetch", 1'b0, rop());
    one_cycle(0, "fetch", 1'b1, rop());
    one_cycle(0, "fetch", 1'b0, rop());
    rst0 = 1'b1;

    run_instr(0, 6'b000000, 0, 0, 1'b0);
    run_instr(0, 6'b100011, 0, 2, 1'b0);
    run_instr(0, 6'b101011, 1, 0, 1'b0);
    run_instr(0, 6'b000101, 0, 0, 1'b0);
    run_instr(0, 6'b001101, 0, 0, 1'b0);
    run_instr(0, 6'b001000, 2, 0, 1'b0);
    run_instr(0, 6'b111111, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] o;
      o = oplist[$urandom_range(0, 8)];
      if (o == 6'b111111) o = rop();
      run_instr(0, o, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset asserted while a store is waiting in the memory-write phase
    one_cycle(0, "fetch", 1'b1, rop());
    one_cycle(0, "decode", rb(), 6'b101011);
    one_cycle(0, "addr", rb(), 6'b101011);
    one_cycle(0, "wr", 1'b0, rop());
    @(posedge clk);
    #1 if0.mem_ready = 1'b0;
    #1 rst0 = 1'b0;
    #1;
    check("rst memwrite", 20'(if0.memwrite), 20'd0);
    check("rst mem_req", 20'(if0.mem_req), 20'd1);
    check("rst regwrite", 20'(if0.regwrite), 20'd0);
    q0.push_back(exp_cv("fetch", 1'b0));
    n0.push_back("fetch in reset");
    one_cycle(0, "fetch", 1'b0, rop());
    rst0 = 1'b1;
    run_instr(0, 6'b000000, 1, 0, 1'b0);

    // u1: no wait states, no extended opcodes, trap halts
    one_cycle(1, "fetch", 1'b0, rop());
    rst1 = 1'b1;
    run_instr(1, 6'b000101, 0, 0, 1'b1);
    repeat (10) one_cycle(1, "trap", 1'b0, rop());
    u1_reset_pulse();
    run_instr(1, 6'b001101, 0, 0, 1'b1);
    repeat (3) one_cycle(1, "trap", 1'b0, rop());
    u1_reset_pulse();
    run_instr(1, 6'b000000, 0, 0, 1'b1);
    run_instr(1, 6'b100011, 0, 0, 1'b0);
    run_instr(1, 6'b101011, 0, 0, 1'b0);
    run_instr(1, 6'b001000, 0, 0, 1'b0);
    run_instr(1, 6'b000010, 0, 0, 1'b0);
    run_instr(1, 6'b111111, 0, 0, 1'b0);
    repeat (10) one_cycle(1, "trap", 1'b0, rop());
    u1_reset_pulse();
    run_instr(1, 6'b000100, 0, 0, 1'b1);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
